pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage RV32I pipeline.
- Consumes the load-use hazard flag (sel_D) from the forwarding unit, plus the EX-stage redirect and I/D memory handshakes.
- Drives the PC load, per-stage pipeline-register load enables, bubble/flush controls and an IF/ID instruction-buffer control.
- Tracks redirects that arrive while an instruction fetch is still outstanding, and squashes the stale fetch.

---
 rtl/rv32i_types.sv | 20 ++
 rtl/hazard_perf_counter.sv | 19 +
 rtl/pipeline_hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: hazard controller state and per-stage
// register control (load enable plus NOP-insert flush).
package rv32i_types;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } hazard_state_t;

  typedef struct packed {
    logic load;
    logic flush;
  } stage_ctrl_t;

  localparam stage_ctrl_t STAGE_HOLD   = '{load: 1'b0, flush: 1'b0};
  localparam stage_ctrl_t STAGE_ADV    = '{load: 1'b1, flush: 1'b0};
  localparam stage_ctrl_t STAGE_BUBBLE = '{load: 1'b1, flush: 1'b1};
  localparam stage_ctrl_t STAGE_RESET  = '{load: 1'b0, flush: 1'b1};

endpackage

// File: rtl/hazard_perf_counter.sv
// Single saturating event counter; sticks at all-ones, cleared by rst.
module hazard_perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline, with redirect
// squash of in-flight fetches. Optional counters under HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import rv32i_types::*;
#(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_use_hazard,
  input  logic                imem_read,
  input  logic                imem_resp,
  input  logic                dmem_read,
  input  logic                dmem_write,
  input  logic                dmem_resp,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_target,
  output logic                pc_load,
  output logic                pc_sel,
  output logic [PC_WIDTH-1:0] pc_redirect,
  output logic                load_if_id,
  output logic                load_id_ex,
  output logic                load_ex_mem,
  output logic                load_mem_wb,
  output logic                flush_if_id,
  output logic                flush_id_ex,
  output logic                flush_ex_mem,
  output logic                ibuf_load,
  output logic                ibuf_sel
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] cnt_dstall,
  output logic [CNT_WIDTH-1:0] cnt_luse,
  output logic [CNT_WIDTH-1:0] cnt_istall,
  output logic [CNT_WIDTH-1:0] cnt_flush
`endif
);

  hazard_state_t       fsm, fsm_n;
  logic                ibuf_valid;
  logic [PC_WIDTH-1:0] redir_q;

  logic        d_stall, i_done, i_stall;
  logic        latch_redir, take_redir;
  stage_ctrl_t if_id_c, id_ex_c, ex_mem_c, mem_wb_c;

  assign d_stall = (dmem_read | dmem_write) & ~dmem_resp;
  assign i_done  = ibuf_valid | (imem_read & imem_resp);
  assign i_stall = imem_read & ~i_done;

  always_comb begin
    pc_load     = 1'b0;
    pc_sel      = 1'b0;
    if_id_c     = STAGE_HOLD;
    id_ex_c     = STAGE_HOLD;
    ex_mem_c    = STAGE_HOLD;
    mem_wb_c    = STAGE_HOLD;
    fsm_n       = fsm;
    latch_redir = 1'b0;
    take_redir  = 1'b0;
    if (rst) begin
      if_id_c  = STAGE_RESET;
      id_ex_c  = STAGE_RESET;
      ex_mem_c = STAGE_RESET;
      mem_wb_c = STAGE_RESET;
    end else if (!d_stall) begin
      // A data miss freezes the whole pipe; everything below assumes MEM moves.
      if (fsm == RUN) begin
        if (load_use_hazard) begin
          ex_mem_c = STAGE_BUBBLE;
          mem_wb_c = STAGE_ADV;
        end else if (redirect_valid && i_stall) begin
          id_ex_c     = STAGE_BUBBLE;
          ex_mem_c    = STAGE_ADV;
          mem_wb_c    = STAGE_ADV;
          latch_redir = 1'b1;
          fsm_n       = SQUASH;
        end else if (redirect_valid) begin
          pc_load    = 1'b1;
          pc_sel     = 1'b1;
          if_id_c    = STAGE_BUBBLE;
          id_ex_c    = STAGE_BUBBLE;
          ex_mem_c   = STAGE_ADV;
          mem_wb_c   = STAGE_ADV;
          take_redir = 1'b1;
        end else if (i_stall) begin
          id_ex_c  = STAGE_BUBBLE;
          ex_mem_c = STAGE_ADV;
          mem_wb_c = STAGE_ADV;
        end else begin
          pc_load  = 1'b1;
          if_id_c  = STAGE_ADV;
          id_ex_c  = STAGE_ADV;
          ex_mem_c = STAGE_ADV;
          mem_wb_c = STAGE_ADV;
        end
      end else begin
        id_ex_c  = STAGE_BUBBLE;
        ex_mem_c = STAGE_ADV;
        mem_wb_c = STAGE_ADV;
        // The fetch that was outstanding at the redirect is stale: drop it.
        if (i_done) begin
          if_id_c = STAGE_BUBBLE;
          pc_load = 1'b1;
          pc_sel  = 1'b1;
          fsm_n   = RUN;
        end
      end
    end
  end

  assign pc_redirect  = (fsm == SQUASH) ? redir_q : redirect_target;
  assign load_if_id   = if_id_c.load;
  assign load_id_ex   = id_ex_c.load;
  assign load_ex_mem  = ex_mem_c.load;
  assign load_mem_wb  = mem_wb_c.load;
  assign flush_if_id  = if_id_c.flush;
  assign flush_id_ex  = id_ex_c.flush;
  assign flush_ex_mem = ex_mem_c.flush;

  // A returning fetch that IF/ID cannot take this cycle is parked in the buffer.
  assign ibuf_load = ~rst & imem_resp & ~if_id_c.load;
  assign ibuf_sel  = ~rst & ibuf_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm        <= RUN;
      ibuf_valid <= 1'b0;
      redir_q    <= '0;
    end else begin
      fsm <= fsm_n;
      if (latch_redir) redir_q <= redirect_target;
      if (if_id_c.load) ibuf_valid <= 1'b0;
      else if (ibuf_load) ibuf_valid <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic luse_evt, istall_evt, flush_evt;

  assign luse_evt   = ~rst & ~d_stall & (fsm == RUN) & load_use_hazard;
  assign istall_evt = ~rst & ~d_stall & i_stall & ~luse_evt;
  assign flush_evt  = latch_redir | take_redir;

  hazard_perf_counter #(.W(CNT_WIDTH)) u_cnt_dstall (
    .clk(clk), .rst(rst), .inc(~rst & d_stall), .cnt(cnt_dstall)
  );
  hazard_perf_counter #(.W(CNT_WIDTH)) u_cnt_luse (
    .clk(clk), .rst(rst), .inc(luse_evt), .cnt(cnt_luse)
  );
  hazard_perf_counter #(.W(CNT_WIDTH)) u_cnt_istall (
    .clk(clk), .rst(rst), .inc(istall_evt), .cnt(cnt_istall)
  );
  hazard_perf_counter #(.W(CNT_WIDTH)) u_cnt_flush (
    .clk(clk), .rst(rst), .inc(flush_evt), .cnt(cnt_flush)
  );
`else
  if (CNT_WIDTH > 0) begin : g_no_perf
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus
// randomized traffic against a stage-action reference model.
module tb_pipeline_hazard_ctrl;

  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_use_hazard, imem_read, imem_resp;
  logic          dmem_read, dmem_write, dmem_resp;
  logic          redirect_valid;
  logic [PW-1:0] redirect_target;
  logic          pc_load, pc_sel;
  logic [PW-1:0] pc_redirect;
  logic          load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic          flush_if_id, flush_id_ex, flush_ex_mem;
  logic          ibuf_load, ibuf_sel;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]   cnt_dstall, cnt_luse, cnt_istall, cnt_flush;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.PC_WIDTH(PW), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .load_use_hazard(load_use_hazard),
    .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_resp(dmem_resp),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .pc_load(pc_load), .pc_sel(pc_sel), .pc_redirect(pc_redirect),
    .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .flush_ex_mem(flush_ex_mem),
    .ibuf_load(ibuf_load), .ibuf_sel(ibuf_sel)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .cnt_dstall(cnt_dstall), .cnt_luse(cnt_luse),
    .cnt_istall(cnt_istall), .cnt_flush(cnt_flush)
`endif
  );

  // Reference model: what each pipeline stage does this cycle.
  typedef enum int {A_HOLD, A_ADV, A_BUB} act_t;
  bit            m_sq, n_sq, m_buf, n_buf;
  logic [PW-1:0] m_tgt, n_tgt, e_tgt;
  act_t          e_ifid, e_idex, e_exmem, e_memwb;
  int            e_pc;  // 0 hold, 1 sequential, 2 redirect
  logic          e_ibuf_load, e_ibuf_sel;

  task automatic model_eval();
    logic dst, idone, ist;
    dst   = (dmem_read | dmem_write) & ~dmem_resp;
    idone = m_buf | (imem_read & imem_resp);
    ist   = imem_read & ~idone;
    e_pc = 0; e_tgt = '0;
    e_ifid = A_HOLD; e_idex = A_HOLD; e_exmem = A_HOLD; e_memwb = A_HOLD;
    n_sq = m_sq; n_tgt = m_tgt;
    if (rst) begin
      n_sq = 1'b0; n_tgt = '0;
    end else if (!dst && !m_sq) begin
      if (load_use_hazard) begin
        e_exmem = A_BUB; e_memwb = A_ADV;
      end else if (redirect_valid && ist) begin
        e_idex = A_BUB; e_exmem = A_ADV; e_memwb = A_ADV;
        n_sq = 1'b1; n_tgt = redirect_target;
      end else if (redirect_valid) begin
        e_pc = 2; e_tgt = redirect_target;
        e_ifid = A_BUB; e_idex = A_BUB; e_exmem = A_ADV; e_memwb = A_ADV;
      end else if (ist) begin
        e_idex = A_BUB; e_exmem = A_ADV; e_memwb = A_ADV;
      end else begin
        e_pc = 1;
        e_ifid = A_ADV; e_idex = A_ADV; e_exmem = A_ADV; e_memwb = A_ADV;
      end
    end else if (!dst) begin
      e_idex = A_BUB; e_exmem = A_ADV; e_memwb = A_ADV;
      if (idone) begin
        e_pc = 2; e_tgt = m_tgt; e_ifid = A_BUB; n_sq = 1'b0;
      end
    end
    e_ibuf_load = ~rst & imem_resp & (e_ifid == A_HOLD);
    e_ibuf_sel  = ~rst & m_buf;
    if (rst || e_ifid != A_HOLD) n_buf = 1'b0;
    else if (e_ibuf_load) n_buf = 1'b1;
    else n_buf = m_buf;
  endtask

  task automatic idle();
    load_use_hazard = 1'b0; imem_read = 1'b0; imem_resp = 1'b0;
    dmem_read = 1'b0; dmem_write = 1'b0; dmem_resp = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dmem_read = 1'($urandom); dmem_resp = 1'($urandom);
    imem_read = 1'b1; imem_resp = 1'b1; redirect_valid = 1'b1;
    redirect_target = 32'h44; load_use_hazard = 1'($urandom);
    @(negedge clk);
    total++;
    if ({pc_load, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
         flush_if_id, flush_id_ex, flush_ex_mem, ibuf_load, ibuf_sel} !== 10'b00000_111_00) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=0000011100",
        {pc_load, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
         flush_if_id, flush_id_ex, flush_ex_mem, ibuf_load, ibuf_sel});
    end
    tick();
    rst = 1'b0;
    idle();
    @(negedge clk);
    total++;
    if ({pc_load, pc_sel, load_if_id, load_id_ex, load_ex_mem, load_mem_wb} !== 6'b101111) begin
      bad++;
      $display("FAIL reset_release got=%b want=101111",
        {pc_load, pc_sel, load_if_id, load_id_ex, load_ex_mem, load_mem_wb});
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    load_use_hazard = 1'b1;
    @(negedge clk);
    total++;
    if ({pc_load, load_if_id, load_id_ex, load_ex_mem, flush_ex_mem, load_mem_wb} !== 6'b000111) begin
      bad++;
      $display("FAIL load_use got=%b want=000111",
        {pc_load, load_if_id, load_id_ex, load_ex_mem, flush_ex_mem, load_mem_wb});
    end
    tick();
    idle();
    @(negedge clk);
    total++;
    if ({pc_load, load_if_id, load_id_ex, load_ex_mem, load_mem_wb} !== 5'b11111) begin
      bad++;
      $display("FAIL load_use_after got=%b want=11111",
        {pc_load, load_if_id, load_id_ex, load_ex_mem, load_mem_wb});
    end
    tick();
  endtask

  task automatic test_redirect();
    do_reset();
    redirect_valid = 1'b1; redirect_target = 32'h60;
    @(negedge clk);
    total++;
    if ({pc_load, pc_sel, load_if_id, flush_if_id, load_id_ex, flush_id_ex,
         load_ex_mem, load_mem_wb} !== 8'hFF || pc_redirect !== 32'h60) begin
      bad++;
      $display("FAIL redirect ctrl=%b want=11111111 target=%h want=00000060",
        {pc_load, pc_sel, load_if_id, flush_if_id, load_id_ex, flush_id_ex,
         load_ex_mem, load_mem_wb}, pc_redirect);
    end
    tick();
    idle();
  endtask

  task automatic test_redirect_squash();
    do_reset();
    imem_read = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h80;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin
        redirect_valid = 1'b0; redirect_target = 32'h1234;
      end
      if (c == 3) imem_resp = 1'b1;
      if (c == 4) idle();
      @(negedge clk);
      total++;
      if (c < 3) begin
        if ({pc_load, load_if_id, load_id_ex, flush_id_ex, load_ex_mem, load_mem_wb} !== 6'b001111) begin
          bad++;
          $display("FAIL squash_wait c=%0d got=%b want=001111", c,
            {pc_load, load_if_id, load_id_ex, flush_id_ex, load_ex_mem, load_mem_wb});
        end
      end else if (c == 3) begin
        if ({pc_load, pc_sel, load_if_id, flush_if_id} !== 4'b1111 || pc_redirect !== 32'h80) begin
          bad++;
          $display("FAIL squash_exit ctrl=%b want=1111 target=%h want=00000080",
            {pc_load, pc_sel, load_if_id, flush_if_id}, pc_redirect);
        end
      end else begin
        if ({pc_load, pc_sel, load_if_id, flush_if_id, load_id_ex, flush_id_ex} !== 6'b101010) begin
          bad++;
          $display("FAIL squash_back_to_run got=%b want=101010",
            {pc_load, pc_sel, load_if_id, flush_if_id, load_id_ex, flush_id_ex});
        end
      end
      tick();
    end
  endtask

  task automatic test_dmiss_ibuf();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      idle();
      dmem_read = (c < 5);
      dmem_resp = (c == 4);
      imem_read = (c < 2);
      imem_resp = (c == 1);
      @(negedge clk);
      total++;
      if (c < 4) begin
        if ({pc_load, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
             ibuf_load, ibuf_sel} !== {5'b00000, c == 1, c >= 2}) begin
          bad++;
          $display("FAIL dmiss_hold c=%0d got=%b want=%b", c,
            {pc_load, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, ibuf_load, ibuf_sel},
            {5'b00000, c == 1, c >= 2});
        end
      end else if (c == 4) begin
        if ({pc_load, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, ibuf_sel} !== 6'b111111) begin
          bad++;
          $display("FAIL dmiss_release got=%b want=111111",
            {pc_load, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, ibuf_sel});
        end
      end else begin
        if ({ibuf_sel, ibuf_load} !== 2'b00) begin
          bad++;
          $display("FAIL dmiss_buf_clear got=%b want=00", {ibuf_sel, ibuf_load});
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_squash();
    do_reset();
    imem_read = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h80;
    tick();
    redirect_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({pc_load, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
         flush_if_id, flush_id_ex, flush_ex_mem} !== 8'b00000111) begin
      bad++;
      $display("FAIL rst_squash got=%b want=00000111",
        {pc_load, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
         flush_if_id, flush_id_ex, flush_ex_mem});
    end
    tick();
    rst = 1'b0;
    imem_resp = 1'b1;
    @(negedge clk);
    total++;
    if ({pc_load, pc_sel, load_if_id, flush_if_id, load_id_ex, flush_id_ex} !== 6'b101010) begin
      bad++;
      $display("FAIL rst_squash_run got=%b want=101010",
        {pc_load, pc_sel, load_if_id, flush_if_id, load_id_ex, flush_id_ex});
    end
    tick();
    idle();
  endtask

  task automatic test_random();
    logic [10:0] exp_v, obs_v, mask;
    for (int i = 0; i < 3000; i++) begin
      rst             = (i == 0) || ($urandom_range(0, 99) == 0);
      dmem_read       = ($urandom_range(0, 3) == 0);
      dmem_write      = ($urandom_range(0, 7) == 0);
      dmem_resp       = 1'($urandom);
      load_use_hazard = ($urandom_range(0, 5) == 0);
      redirect_valid  = ($urandom_range(0, 5) == 0);
      redirect_target = $urandom & 32'hFFFF_FFFC;
      imem_read       = 1'($urandom);
      imem_resp       = imem_read & ~m_buf & 1'($urandom);
      model_eval();
      @(negedge clk);
      exp_v = {e_pc != 0, e_pc == 2, e_ifid != A_HOLD, e_idex != A_HOLD,
               e_exmem != A_HOLD, e_memwb != A_HOLD,
               rst | (e_ifid == A_BUB), rst | (e_idex == A_BUB),
               rst | (e_exmem == A_BUB), e_ibuf_load, e_ibuf_sel};
      obs_v = {pc_load, pc_sel, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               flush_if_id, flush_id_ex, flush_ex_mem, ibuf_load, ibuf_sel};
      mask = 11'h7FF;
      if (e_pc == 0) mask[9] = 1'b0;
      if (!rst && e_ifid == A_HOLD) mask[4] = 1'b0;
      if (!rst && e_idex == A_HOLD) mask[3] = 1'b0;
      if (!rst && e_exmem == A_HOLD) mask[2] = 1'b0;
      total++;
      if ((obs_v & mask) !== (exp_v & mask)) begin
        bad++;
        $display("FAIL random_ctrl cyc=%0d got=%b want=%b mask=%b", i, obs_v, exp_v, mask);
      end
      if (e_pc == 2) begin
        total++;
        if (pc_redirect !== e_tgt) begin
          bad++;
          $display("FAIL random_target cyc=%0d got=%h want=%h", i, pc_redirect, e_tgt);
        end
      end
      m_sq = n_sq; m_tgt = n_tgt; m_buf = n_buf;
      tick();
    end
  endtask

  initial begin
    m_sq = 1'b0; m_tgt = '0; m_buf = 1'b0;
    rst = 1'b1;
    idle();
    tick();
    test_reset();
    test_load_use();
    test_redirect();
    test_redirect_squash();
    test_dmiss_ibuf();
    test_reset_mid_squash();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
